// File: rtl/fscpu_dispatch.sv
// Request dispatcher: sequences start/abort/config requests over a set of channels (IDLE/ARM/RUN).
// Optional timeout counter is compiled in with `define FSCPU_DISPATCH_TIMEOUT_EN.
module fscpu_dispatch #(
    parameter int unsigned C_CHANNELS      = 4,
    parameter int unsigned C_TIMEOUT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_en,
    input  logic [31:0]           req_cmd,
    input  logic [127:0]          req_param,
    output logic                  req_done,
    output logic [31:0]           req_err,
    output logic                  req_rejected,
    output logic                  busy,
    output logic [C_CHANNELS-1:0] ch_run,
    input  logic [C_CHANNELS-1:0] ch_done,
    output logic [127:0]          ch_param
);

    localparam logic [31:0] CMD_CFG   = 32'd0;
    localparam logic [31:0] CMD_START = 32'd1;
    localparam logic [31:0] CMD_ABORT = 32'd2;
    localparam logic [7:0]  ERR_OK    = 8'd0;
    localparam logic [7:0]  ERR_CMD   = 8'd1;
    localparam logic [7:0]  ERR_MASK  = 8'd3;
    localparam logic [7:0]  ERR_TMO   = 8'd4;
    localparam logic [7:0]  ERR_ABORT = 8'd5;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [C_CHANNELS-1:0] mask;
    logic [C_CHANNELS-1:0] mask_nxt;
    logic [C_CHANNELS-1:0] start_mask;
    logic [C_CHANNELS-1:0] run_nxt;
    logic [127:0]          param_nxt;
    logic [31:0]           err_nxt;
    logic                  done_nxt;
    logic                  rej_nxt;
    logic                  all_done;
    logic                  abort_hit;
    logic                  timeout;
    logic [15:0]           pend_mask;

    assign start_mask = req_param[C_CHANNELS-1:0];
    // Completion is only honoured in RUN so stale ch_done levels seen in ARM are masked.
    assign all_done   = (state == S_RUN) && ((ch_done & mask) == mask);
    assign abort_hit  = req_en && (req_cmd == CMD_ABORT) && (state != S_IDLE);
    assign pend_mask  = 16'(mask & ~ch_done);

`ifdef FSCPU_DISPATCH_TIMEOUT_EN
    logic [C_TIMEOUT_WIDTH-1:0] limit;
    logic [C_TIMEOUT_WIDTH-1:0] count;
    logic [C_TIMEOUT_WIDTH-1:0] count_inc;

    // count_inc is the number of ARM+RUN cycles including the current one.
    assign count_inc = count + C_TIMEOUT_WIDTH'(1);
    assign timeout   = (state != S_IDLE) && (limit != '0) && (count_inc == limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            limit <= '0;
            count <= '0;
        end else begin
            if (state == S_IDLE && req_en && req_cmd == CMD_CFG)
                limit <= req_param[C_TIMEOUT_WIDTH-1:0];
            count <= (state == S_IDLE) ? '0 : count_inc;
        end
    end
`else
    logic unused_timeout_width;
    assign unused_timeout_width = C_TIMEOUT_WIDTH[0];
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req_en && req_cmd == CMD_START && start_mask != '0) state_nxt = S_ARM;
            S_ARM:  state_nxt = (timeout || abort_hit) ? S_IDLE : S_RUN;
            S_RUN:  if (all_done || timeout || abort_hit) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs; priority completion > timeout > abort.
    always_comb begin
        done_nxt  = req_done;
        err_nxt   = req_err;
        rej_nxt   = 1'b0;
        run_nxt   = ch_run;
        mask_nxt  = mask;
        param_nxt = ch_param;
        case (state)
            S_IDLE: begin
                if (req_en) begin
                    done_nxt = 1'b1;
                    if (req_cmd == CMD_CFG) begin
                        err_nxt = {24'h0, ERR_OK};
                    end else if (req_cmd == CMD_START) begin
                        if (start_mask != '0) begin
                            done_nxt  = 1'b0;
                            err_nxt   = '0;
                            mask_nxt  = start_mask;
                            param_nxt = req_param;
                            run_nxt   = start_mask;
                        end else begin
                            err_nxt = {24'h0, ERR_MASK};
                        end
                    end else begin
                        err_nxt = {24'h0, ERR_CMD};
                    end
                end
            end
            S_ARM, S_RUN: begin
                if (req_en && req_cmd != CMD_ABORT) rej_nxt = 1'b1;
                if (all_done) begin
                    run_nxt  = '0;
                    done_nxt = 1'b1;
                    err_nxt  = {24'h0, ERR_OK};
                    if (abort_hit) rej_nxt = 1'b1;
                end else if (timeout) begin
                    run_nxt  = '0;
                    done_nxt = 1'b1;
                    err_nxt  = {pend_mask, 8'h00, ERR_TMO};
                    if (abort_hit) rej_nxt = 1'b1;
                end else if (abort_hit) begin
                    run_nxt  = '0;
                    done_nxt = 1'b1;
                    err_nxt  = {pend_mask, 8'h00, ERR_ABORT};
                end
            end
            default: run_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_done     <= 1'b0;
            req_err      <= '0;
            req_rejected <= 1'b0;
            busy         <= 1'b0;
            ch_run       <= '0;
            ch_param     <= '0;
            mask         <= '0;
        end else begin
            req_done     <= done_nxt;
            req_err      <= err_nxt;
            req_rejected <= rej_nxt;
            busy         <= (state_nxt != S_IDLE);
            ch_run       <= run_nxt;
            ch_param     <= param_nxt;
            mask         <= mask_nxt;
        end
    end

endmodule

// File: tb/tb_fscpu_dispatch.sv
// Directed self-checking bench for fscpu_dispatch (default 4 channels).
module tb_fscpu_dispatch;

    logic         clk;
    logic         reset;
    logic         req_en;
    logic [31:0]  req_cmd;
    logic [127:0] req_param;
    logic         req_done;
    logic [31:0]  req_err;
    logic         req_rejected;
    logic         busy;
    logic [3:0]   ch_run;
    logic [3:0]   ch_done;
    logic [127:0] ch_param;

    int vectors;
    int miscompares;

    localparam logic [127:0] PAR_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_0000_0005;

    fscpu_dispatch #(.C_CHANNELS(4), .C_TIMEOUT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .req_en(req_en), .req_cmd(req_cmd),
        .req_param(req_param), .req_done(req_done), .req_err(req_err),
        .req_rejected(req_rejected), .busy(busy), .ch_run(ch_run),
        .ch_done(ch_done), .ch_param(ch_param)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] cmd, input logic [127:0] par);
        req_en    = 1'b1;
        req_cmd   = cmd;
        req_param = par;
        step();
        req_en    = 1'b0;
        req_cmd   = '0;
        req_param = '0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        req_en      = 1'b0;
        req_cmd     = '0;
        req_param   = '0;
        ch_done     = '0;
        #12;
        chk("rst_done", 128'(req_done), 128'h0);
        chk("rst_err", 128'(req_err), 128'h0);
        chk("rst_run", 128'(ch_run), 128'h0);
        chk("rst_busy", 128'(busy), 128'h0);
        chk("rst_rej", 128'(req_rejected), 128'h0);
        chk("rst_param", ch_param, 128'h0);
        reset = 1'b0;
        step();

        // Normal run, completion three cycles after start
        issue(32'd1, PAR_A);
        chk("run5_chrun", 128'(ch_run), 128'h5);
        chk("run5_busy", 128'(busy), 128'h1);
        chk("run5_done0", 128'(req_done), 128'h0);
        chk("run5_param", ch_param, PAR_A);
        step(); step(); step();
        ch_done = 4'h5;
        chk("run5_notyet", 128'(req_done), 128'h0);
        step();
        chk("run5_done", 128'(req_done), 128'h1);
        chk("run5_err", 128'(req_err), 128'h0);
        chk("run5_chrun0", 128'(ch_run), 128'h0);
        chk("run5_idle", 128'(busy), 128'h0);
        ch_done = 4'h0;

        // Invalid commands in IDLE
        issue(32'd7, 128'h0);
        chk("cmd7_done", 128'(req_done), 128'h1);
        chk("cmd7_err", 128'(req_err), 128'h1);
        issue(32'd2, 128'h0);
        chk("idle_abort_err", 128'(req_err), 128'h1);
        issue(32'd1, 128'h0);
        chk("zmask_err", 128'(req_err), 128'h3);
        chk("zmask_run", 128'(ch_run), 128'h0);
        chk("zmask_busy", 128'(busy), 128'h0);

        // Stale ch_done held before start must not complete in ARM
        ch_done = 4'hF;
        issue(32'd1, 128'hF);
        chk("stale_run", 128'(ch_run), 128'hF);
        step();
        chk("stale_arm_done", 128'(req_done), 128'h0);
        chk("stale_arm_run", 128'(ch_run), 128'hF);
        step();
        chk("stale_done", 128'(req_done), 128'h1);
        chk("stale_err", 128'(req_err), 128'h0);
        chk("stale_run0", 128'(ch_run), 128'h0);
        ch_done = 4'h0;

        // Reject non-abort while running, then abort
        issue(32'd1, 128'h2);
        step(); step();
        issue(32'd1, 128'h2);
        chk("rej_pulse", 128'(req_rejected), 128'h1);
        chk("rej_still_run", 128'(ch_run), 128'h2);
        chk("rej_done0", 128'(req_done), 128'h0);
        step();
        chk("rej_pulse_end", 128'(req_rejected), 128'h0);
        issue(32'd2, 128'h0);
        chk("abort_err", 128'(req_err), 128'h0002_0005);
        chk("abort_done", 128'(req_done), 128'h1);
        chk("abort_run0", 128'(ch_run), 128'h0);

        // Completion beats simultaneous abort; abort is rejected
        issue(32'd1, 128'h1);
        step(); step();
        ch_done = 4'h1;
        issue(32'd2, 128'h0);
        chk("prio_err", 128'(req_err), 128'h0);
        chk("prio_done", 128'(req_done), 128'h1);
        chk("prio_rej", 128'(req_rejected), 128'h1);
        ch_done = 4'h0;

        // Config followed by a run that only half completes
        issue(32'd0, 128'd10);
        chk("cfg_done", 128'(req_done), 128'h1);
        chk("cfg_err", 128'(req_err), 128'h0);
        ch_done = 4'h1;
        issue(32'd1, 128'h3);
`ifdef FSCPU_DISPATCH_TIMEOUT_EN
        for (int i = 0; i < 9; i++) step();
        chk("tmo_before", 128'(req_done), 128'h0);
        step();
        chk("tmo_done", 128'(req_done), 128'h1);
        chk("tmo_err", 128'(req_err), 128'h0002_0004);
        chk("tmo_run0", 128'(ch_run), 128'h0);
        issue(32'd0, 128'd0);
`else
        for (int i = 0; i < 12; i++) step();
        chk("notmo_done", 128'(req_done), 128'h0);
        chk("notmo_run", 128'(ch_run), 128'h3);
        issue(32'd2, 128'h0);
        chk("notmo_abort", 128'(req_err), 128'h0002_0005);
`endif
        ch_done = 4'h0;

        // Asynchronous reset in the middle of a run
        issue(32'd1, 128'hF);
        step(); step();
        #3;
        reset = 1'b1;
        #1;
        chk("mrst_run", 128'(ch_run), 128'h0);
        chk("mrst_done", 128'(req_done), 128'h0);
        chk("mrst_busy", 128'(busy), 128'h0);
        reset = 1'b0;
        step();
        chk("mrst_idle_run", 128'(ch_run), 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
